// File: rtl/pipemem_io_pkg.sv
// Shared constants for the MEM-stage memory/IO unit: IO register map,
// timer control bit layout and load/store size encodings.
package pipemem_io_pkg;

    localparam logic [4:0] IDX_IN   = 5'd0;
    localparam logic [4:0] IDX_OUT  = 5'd8;
    localparam logic [4:0] IDX_STAT = 5'd16;
    localparam logic [4:0] IDX_TCNT = 5'd17;
    localparam logic [4:0] IDX_TCMP = 5'd18;
    localparam logic [4:0] IDX_TCTL = 5'd19;

    localparam int TCTL_EN   = 0;
    localparam int TCTL_AC   = 1;
    localparam int TCTL_IE   = 2;
    localparam int TCTL_FLAG = 3;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Field order matches the TCTL bit positions above (en is bit 0).
    typedef struct packed {
        logic flag;
        logic ie;
        logic ac;
        logic en;
    } tctl_t;

endpackage

// File: rtl/pipemem_io_dram_be.sv
// Data RAM with per-byte write enables: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module dram_be #(
    parameter int DMEM_WORDS = 32
) (
    input  logic                          clock,
    input  logic                          we,
    input  logic [3:0]                    be,
    input  logic [$clog2(DMEM_WORDS)-1:0] addr,
    input  logic [31:0]                   wdata,
    output logic [31:0]                   rdata
);

    logic [31:0] mem [DMEM_WORDS];

    always_ff @(posedge clock) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/pipemem_io.sv
// MEM-stage memory/IO unit: sub-word RAM access, synchronised input ports,
// registered output ports and a compare timer, all memory-mapped.
module pipemem_io
    import pipemem_io_pkg::*;
#(
    parameter int DMEM_WORDS = 32,
    parameter int N_IN       = 2,
    parameter int IN_W       = 4,
    parameter int N_OUT      = 3,
    parameter int IO_BIT     = 7
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 mwmem,
    input  logic [31:0]          malu,
    input  logic [31:0]          mb,
    input  logic [31:0]          wmo,
    input  logic                 wm2reg,
    input  logic [1:0]           msize,
    input  logic                 munsigned,
    input  logic [N_IN*IN_W-1:0] in_port,
    output logic [31:0]          mmo,
    output logic [N_OUT*32-1:0]  out_port,
    output logic                 timer_irq
);

    localparam int AW = $clog2(DMEM_WORDS);

    logic [31:0]          datain;
    logic                 io;
    logic [4:0]           k;
    logic                 io_we;
    logic                 ram_we;
    logic [3:0]           ram_be;
    logic [31:0]          ram_wdata;
    logic [31:0]          ram_word;
    logic [31:0]          io_rd;
    logic [31:0]          out_reg [N_OUT];
    logic [N_IN*IN_W-1:0] s1, s2, s3;
    logic [N_IN-1:0]      stat, chg, stat_clr;
    logic [31:0]          tcnt, tcmp;
    tctl_t                tctl;
    logic                 match;
    logic                 wr_stat, wr_tcnt, wr_tcmp, wr_tctl;
    logic                 unused_addr;

    // Address bits outside the RAM index and IO index only alias.
    assign unused_addr = ^malu;

    assign datain = wm2reg ? wmo : mb;
    assign io     = malu[IO_BIT];
    assign k      = malu[6:2];
    assign io_we  = mwmem & io;
    // Gating with resetn keeps a store from landing while reset is held.
    assign ram_we = mwmem & ~io & resetn;

    assign wr_stat = io_we && (k == IDX_STAT);
    assign wr_tcnt = io_we && (k == IDX_TCNT);
    assign wr_tcmp = io_we && (k == IDX_TCMP);
    assign wr_tctl = io_we && (k == IDX_TCTL);

    always_comb begin
        ram_be    = 4'b1111;
        ram_wdata = datain;
        case (msize)
            SZ_BYTE: begin
                ram_be    = 4'b0001 << malu[1:0];
                ram_wdata = {4{datain[7:0]}};
            end
            SZ_HALF: begin
                ram_be    = malu[1] ? 4'b1100 : 4'b0011;
                ram_wdata = {2{datain[15:0]}};
            end
            default: ;
        endcase
    end

    dram_be #(.DMEM_WORDS(DMEM_WORDS)) u_dram (
        .clock (clock),
        .we    (ram_we),
        .be    (ram_be),
        .addr  (malu[AW+1:2]),
        .wdata (ram_wdata),
        .rdata (ram_word)
    );

    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] off,
                                             input logic [1:0] sz, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (sz)
            SZ_BYTE: return uns ? {24'd0, b} : {{24{b[7]}}, b};
            SZ_HALF: return uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: return w;
        endcase
    endfunction

    always_comb begin
        for (int i = 0; i < N_IN; i++)
            chg[i] = s2[i*IN_W +: IN_W] != s3[i*IN_W +: IN_W];
    end

    assign stat_clr  = wr_stat ? datain[N_IN-1:0] : '0;
    assign match     = tcnt == tcmp;
    assign timer_irq = tctl.flag & tctl.ie;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s1   <= '0;
            s2   <= '0;
            s3   <= '0;
            stat <= '0;
            tcnt <= '0;
            tcmp <= '0;
            tctl <= '0;
            for (int j = 0; j < N_OUT; j++) out_reg[j] <= '0;
        end else begin
            s1   <= in_port;
            s2   <= s1;
            s3   <= s2;
            // Set beats W1C for both STAT and the timer match flag.
            stat <= (stat & ~stat_clr) | chg;
            for (int j = 0; j < N_OUT; j++) begin
                if (io_we && (k == 5'(IDX_OUT + j))) out_reg[j] <= datain;
            end
            if (wr_tcmp) tcmp <= datain;
            if (wr_tcnt)
                tcnt <= datain;
            else if (tctl.en)
                tcnt <= (match && tctl.ac) ? 32'd0 : tcnt + 32'd1;
            if (wr_tctl) begin
                tctl.en <= datain[TCTL_EN];
                tctl.ac <= datain[TCTL_AC];
                tctl.ie <= datain[TCTL_IE];
            end
            tctl.flag <= (tctl.flag & ~(wr_tctl & datain[TCTL_FLAG])) | (tctl.en & match);
        end
    end

    always_comb begin
        io_rd = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (k == 5'(IDX_IN + i)) io_rd = 32'(s2[i*IN_W +: IN_W]);
        end
        for (int j = 0; j < N_OUT; j++) begin
            if (k == 5'(IDX_OUT + j)) io_rd = out_reg[j];
        end
        case (k)
            IDX_STAT: io_rd = 32'(stat);
            IDX_TCNT: io_rd = tcnt;
            IDX_TCMP: io_rd = tcmp;
            IDX_TCTL: io_rd = {28'd0, tctl};
            default: ;
        endcase
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_out
        assign out_port[j*32 +: 32] = out_reg[j];
    end

    assign mmo = io ? io_rd : load_ext(ram_word, malu[1:0], msize, munsigned);

endmodule

// File: doc/pipemem_io.md
Name: pipemem_io

Overview:
Parametrised MEM-stage memory/IO unit for the 5-stage MIPS32 pipeline, sitting between the EX/MEM and MEM/WB registers. It adds the following over the fixed single-word design:
- byte/half/word loads and stores with sign/zero extension
- configurable data-RAM depth
- configurable input/output port counts
- input-port synchronisers with sticky change flags
- a memory-mapped timer with compare interrupt
Single clock domain; the RAM is clocked by `clock`, with no separate memory clock.

Parameters:
DMEM_WORDS, 32, data RAM depth in 32-bit words; power of 2, 4..1024
N_IN, 2, number of input ports, 1..8
IN_W, 4, width of each input port, 1..32
N_OUT, 3, number of 32-bit output ports, 1..8
IO_BIT, 7, address bit selecting IO (1) vs RAM (0); must exceed log2(DMEM_WORDS)+1

Ports:
clock  in  1  pipeline clock, all state on rising edge
resetn  in  1  asynchronous active-low reset
mwmem  in  1  store enable from EX/MEM
malu  in  32  byte address from EX/MEM
mb  in  32  store data from EX/MEM
wmo  in  32  WB-stage load data (forwarding source)
wm2reg  in  1  select wmo instead of mb as store data
msize  in  2  00 byte, 01 half, 10 word, 11 treated as word
munsigned  in  1  zero-extend byte/half loads
in_port  in  N_IN*IN_W  input ports, port i at [i*IN_W +: IN_W]
mmo  out  32  load data to MEM/WB (combinational)
out_port  out  N_OUT*32  registered output ports, port j at [j*32 +: 32]
timer_irq  out  1  level interrupt, equals timer flag AND irq-enable

Behaviour:
- Store data: datain = wm2reg ? wmo : mb.
- Region select: io = malu[IO_BIT]. RAM word index = malu[log2(DMEM_WORDS)+1:2]; upper bits are ignored (aliasing).
- RAM store (mwmem & !io) is synchronous. Byte lanes by size:
  - byte: lane malu[1:0] gets datain[7:0]
  - half: lanes {malu[1],0} and {malu[1],1} get datain[15:0]; malu[0] ignored
  - word: all four lanes
- RAM read is asynchronous. mmo selects byte/half as above, then sign- or zero-extends per munsigned. The RAM is not reset.
- IO access is word-only; msize and malu[1:0] are ignored. IO index k = malu[6:2]. Map:
  - k=0..N_IN-1: read synchronised input i, zero-extended; writes ignored.
  - k=8..8+N_OUT-1: read/write output register j; a write updates out_port at the next edge.
  - k=16 STAT: read returns bit i = change flag i. Write is W1C on those bits.
  - k=17 TCNT: read/write counter.
  - k=18 TCMP: read/write compare value.
  - k=19 TCTL: bit0 enable, bit1 auto-clear, bit2 irq enable (all R/W); bit3 match flag (read, W1C).
  - Any other k reads 0; writes to it are ignored.
- Input path: 2-flop synchroniser (s1, s2) plus a history flop s3. Reads return s2. Flag i sets when s2[i] != s3[i].
  - A change sampled at edge t is readable after edge t+1; its flag is set after edge t+2.
- Timer: while enable=1, each cycle TCNT <= (TCNT==TCMP && autoclear) ? 0 : TCNT+1, wrapping at 2^32-1 to 0.
  - The match flag sets on any enabled cycle where TCNT==TCMP.
  - While disabled, TCNT holds and no match occurs.
- Simultaneous events:
  - A software write to TCNT wins over increment/auto-clear.
  - Flag set wins over W1C in the same cycle, for both STAT and TCTL.
  - A write to TCMP takes effect for comparison from the next cycle.
- Reset (asynchronous, resetn=0): out_port, s1/s2/s3, STAT flags, TCNT, TCMP, TCTL and timer_irq all go to 0. Reset mid-store discards the store.
- Latency: loads are combinational in MEM; stores and IO writes commit at the MEM-cycle edge.

Decomposition:
- Package pipemem_io_pkg holds:
  - IO index constants IDX_IN=0, IDX_OUT=8, IDX_STAT=16, IDX_TCNT=17, IDX_TCMP=18, IDX_TCTL=19
  - TCTL bit positions
  - msize encodings SZ_BYTE/SZ_HALF/SZ_WORD
- Sub-module dram_be: DMEM_WORDS x 32 RAM with 4 byte-write enables, synchronous write, asynchronous read.
- Load extension, IO decode, synchroniser and timer stay in the top module.

Test Plan:
- Sub-word stores then loads: sw 0x80FF7F01 @0x04, then:
  - lb @0x04 -> 0x00000001; lb @0x07 -> 0xFFFFFF80
  - lbu @0x07 -> 0x00000080; lh @0x06 -> 0xFFFF80FF
  - sb 0xAA @0x05, then lw @0x04 -> 0x80FFAA01
- Forwarding and out ports: wm2reg=1, wmo=0x1234, store @0x80+8*4 -> out_port[0]=0x1234 next cycle, reads back 0x1234; mb is ignored.
- Input sync and flag: in_port0 changes 0->0x5 -> IO read k=0 gives 5 after 2 edges, STAT bit0=1 after 3 edges. Write STAT=1 clears it. Changing input in the same cycle as the W1C leaves the flag set.
- Timer, auto-clear on:
  - TCMP=3, TCTL=0b111 -> TCNT sequence 0,1,2,3,0,...; flag and timer_irq rise after the match cycle.
  - W1C bit3 drops timer_irq unless a new match occurs that cycle.
- Timer write priority and wrap:
  - TCNT=0xFFFFFFFF with autoclear=0, TCMP=0 -> wraps to 0, then matches.
  - Writing TCNT=10 while enabled -> next value 10, not incremented.
- Async reset mid-operation: assert resetn=0 between edges with timer running and outputs set -> immediately out_port=0, TCNT=0, timer_irq=0, STAT=0. A store issued in that cycle does not commit to IO registers.
